// File: rtl/core_trap_seq_pkg.sv
// Shared types and constants for the trap-entry / MRET sequencer.
package core_trap_seq_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_W_MEPC    = 3'd1;
  localparam logic [2:0] ST_W_MCAUSE  = 3'd2;
  localparam logic [2:0] ST_W_MTVAL   = 3'd3;
  localparam logic [2:0] ST_W_MSTATUS = 3'd4;
  localparam logic [2:0] ST_R_MSTATUS = 3'd5;
  localparam logic [2:0] ST_REDIRECT  = 3'd6;

  typedef enum logic [3:0] {
    CAUSE_INSTR_MIS = 4'd0,
    CAUSE_ILLEGAL   = 4'd2,
    CAUSE_EBREAK    = 4'd3,
    CAUSE_LOAD_MIS  = 4'd4,
    CAUSE_STORE_MIS = 4'd6,
    CAUSE_ECALL_U   = 4'd8,
    CAUSE_ECALL_M   = 4'd11
  } trap_cause_e;

  typedef enum logic [1:0] {
    TVAL_ZERO   = 2'd0,
    TVAL_INSTR  = 2'd1,
    TVAL_PC_NEW = 2'd2,
    TVAL_MEM    = 2'd3
  } tval_sel_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

endpackage

// File: rtl/core_trap_seq_if.sv
// CSR write port plus fetch redirect / privilege update strobes of the trap sequencer.
interface core_trap_seq_if #(parameter int XLEN = 32);
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_wack;
  logic            pc_redirect_valid;
  logic [XLEN-1:0] pc_redirect;
  logic            priv_set_valid;
  logic [1:0]      priv_set;

  modport master (
    output csr_we, csr_waddr, csr_wdata, pc_redirect_valid, pc_redirect,
           priv_set_valid, priv_set,
    input  csr_wack
  );

  modport slave (
    input  csr_we, csr_waddr, csr_wdata, pc_redirect_valid, pc_redirect,
           priv_set_valid, priv_set,
    output csr_wack
  );
endinterface

// File: rtl/core_trap_seq_prio.sv
// Combinational priority encoder: exception/interrupt flags -> one trap event.
module core_trap_prio
  import core_trap_seq_pkg::*;
(
  input  logic       illegal_instr,
  input  logic       instr_misaligned,
  input  logic       ecall,
  input  logic       ebreak,
  input  logic       store_misaligned,
  input  logic       load_misaligned,
  input  logic       irq_pending,
  input  logic [3:0] irq_cause,
  input  logic       instr_boundary,
  input  logic [1:0] priv,
  output logic       valid,
  output logic       is_irq,
  output logic [3:0] cause,
  output tval_sel_e  tval_sel
);

  // Highest-priority flag wins; interrupts only at an instruction boundary.
  always_comb begin
    valid    = 1'b1;
    is_irq   = 1'b0;
    cause    = 4'd0;
    tval_sel = TVAL_ZERO;
    if (illegal_instr) begin
      cause    = CAUSE_ILLEGAL;
      tval_sel = TVAL_INSTR;
    end else if (instr_misaligned) begin
      cause    = CAUSE_INSTR_MIS;
      tval_sel = TVAL_PC_NEW;
    end else if (ecall) begin
      cause = (priv == PRIV_M) ? CAUSE_ECALL_M : CAUSE_ECALL_U;
    end else if (ebreak) begin
      cause = CAUSE_EBREAK;
    end else if (store_misaligned) begin
      cause    = CAUSE_STORE_MIS;
      tval_sel = TVAL_MEM;
    end else if (load_misaligned) begin
      cause    = CAUSE_LOAD_MIS;
      tval_sel = TVAL_MEM;
    end else if (irq_pending && instr_boundary) begin
      is_irq = 1'b1;
      cause  = irq_cause;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/core_trap_seq.sv
// Trap-entry / MRET sequencer: serialises CSR updates over one write port,
// then redirects fetch and updates privilege.
//
//   state        | meaning
//   ST_IDLE      | waiting for exception, interrupt or MRET
//   ST_W_MEPC    | writing mepc
//   ST_W_MCAUSE  | writing mcause
//   ST_W_MTVAL   | writing mtval
//   ST_W_MSTATUS | writing mstatus (trap entry form)
//   ST_R_MSTATUS | writing mstatus (MRET form)
//   ST_REDIRECT  | one-cycle fetch redirect + privilege update
module core_trap_seq
  import core_trap_seq_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit VECTORED = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_exec_illegal_instr,
  input  logic            ex_instr_misaligned,
  input  logic            ex_ecall,
  input  logic            ex_ebreak,
  input  logic            ex_load_misaligned,
  input  logic            ex_store_misaligned,
  input  logic            irq_pending,
  input  logic [3:0]      irq_cause,
  input  logic            instr_boundary,
  input  logic            mret,
  input  logic [1:0]      priv,
  input  logic [XLEN-1:0] exec_pc,
  input  logic [XLEN-1:0] pc_new,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] mstatus,
  output logic            trap_busy,
  core_trap_seq_if.master csr_bus
);

  logic [2:0]      state_q;
  logic [3:0]      cause_q;
  logic            is_irq_q;
  logic            is_mret_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] target_q;
  logic [1:0]      priv_q;

  logic            ev_valid;
  logic            ev_is_irq;
  logic [3:0]      ev_cause;
  tval_sel_e       ev_tval_sel;
  logic [XLEN-1:0] ev_tval;
  logic [XLEN-1:0] ms_trap;
  logic [XLEN-1:0] ms_mret;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] mcause_w;

  core_trap_prio u_prio (
    .illegal_instr    (ex_exec_illegal_instr),
    .instr_misaligned (ex_instr_misaligned),
    .ecall            (ex_ecall),
    .ebreak           (ex_ebreak),
    .store_misaligned (ex_store_misaligned),
    .load_misaligned  (ex_load_misaligned),
    .irq_pending      (irq_pending),
    .irq_cause        (irq_cause),
    .instr_boundary   (instr_boundary),
    .priv             (priv),
    .valid            (ev_valid),
    .is_irq           (ev_is_irq),
    .cause            (ev_cause),
    .tval_sel         (ev_tval_sel)
  );

  // Values captured at IDLE exit: tval, both mstatus forms and the trap target.
  // Everything is frozen at that edge so the write data stays stable while
  // the CSR port back-pressures.
  always_comb begin
    case (ev_tval_sel)
      TVAL_INSTR:  ev_tval = XLEN'(instr);
      TVAL_PC_NEW: ev_tval = pc_new;
      TVAL_MEM:    ev_tval = mem_addr;
      default:     ev_tval = '0;
    endcase
    ms_trap = mstatus;
    ms_trap[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
    ms_trap[MSTATUS_MIE]  = 1'b0;
    ms_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv;
    ms_mret = mstatus;
    ms_mret[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
    ms_mret[MSTATUS_MPIE] = 1'b1;
    ms_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
    trap_target = (mtvec & ~(XLEN'(3)))
                + ((VECTORED && mtvec[0] && ev_is_irq) ? (XLEN'(ev_cause) << 2) : '0);
  end

  // Sequencer state and captured event; sync reset abandons any sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cause_q   <= '0;
      is_irq_q  <= 1'b0;
      is_mret_q <= 1'b0;
      tval_q    <= '0;
      epc_q     <= '0;
      mstatus_q <= '0;
      target_q  <= '0;
      priv_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ev_valid) begin
            cause_q   <= ev_cause;
            is_irq_q  <= ev_is_irq;
            is_mret_q <= 1'b0;
            tval_q    <= ev_tval;
            epc_q     <= exec_pc & ~(XLEN'(3));
            mstatus_q <= ms_trap;
            target_q  <= trap_target;
            priv_q    <= PRIV_M;
            state_q   <= ST_W_MEPC;
          end else if (mret) begin
            is_mret_q <= 1'b1;
            mstatus_q <= ms_mret;
            target_q  <= mepc & ~(XLEN'(1));
            priv_q    <= mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
            state_q   <= ST_R_MSTATUS;
          end
        end
        ST_W_MEPC:    if (csr_bus.csr_wack) state_q <= ST_W_MCAUSE;
        ST_W_MCAUSE:  if (csr_bus.csr_wack) state_q <= ST_W_MTVAL;
        ST_W_MTVAL:   if (csr_bus.csr_wack) state_q <= ST_W_MSTATUS;
        ST_W_MSTATUS: if (csr_bus.csr_wack) state_q <= ST_REDIRECT;
        ST_R_MSTATUS: if (csr_bus.csr_wack) state_q <= ST_REDIRECT;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from state; all zero in IDLE.
  always_comb begin
    mcause_w               = XLEN'(cause_q);
    mcause_w[XLEN-1]       = is_irq_q;
    trap_busy              = (state_q != ST_IDLE);
    csr_bus.csr_we         = 1'b0;
    csr_bus.csr_waddr      = '0;
    csr_bus.csr_wdata      = '0;
    csr_bus.pc_redirect_valid = 1'b0;
    csr_bus.pc_redirect    = '0;
    csr_bus.priv_set_valid = 1'b0;
    csr_bus.priv_set       = '0;
    case (state_q)
      ST_W_MEPC: begin
        csr_bus.csr_we    = 1'b1;
        csr_bus.csr_waddr = CSR_MEPC;
        csr_bus.csr_wdata = epc_q;
      end
      ST_W_MCAUSE: begin
        csr_bus.csr_we    = 1'b1;
        csr_bus.csr_waddr = CSR_MCAUSE;
        csr_bus.csr_wdata = mcause_w;
      end
      ST_W_MTVAL: begin
        csr_bus.csr_we    = 1'b1;
        csr_bus.csr_waddr = CSR_MTVAL;
        csr_bus.csr_wdata = tval_q;
      end
      ST_W_MSTATUS, ST_R_MSTATUS: begin
        csr_bus.csr_we    = 1'b1;
        csr_bus.csr_waddr = CSR_MSTATUS;
        csr_bus.csr_wdata = mstatus_q;
      end
      ST_REDIRECT: begin
        csr_bus.pc_redirect_valid = 1'b1;
        csr_bus.pc_redirect       = target_q;
        csr_bus.priv_set_valid    = 1'b1;
        csr_bus.priv_set          = is_mret_q ? priv_q : PRIV_M;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_trap_seq.sv
// Bench for core_trap_seq: event-level model predicting CSR writes and redirect.
module tb_core_trap_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ill, imis, ecall, ebreak, lmis, smis;
  logic        irq_pending, instr_boundary, mret;
  logic [3:0]  irq_cause;
  logic [1:0]  priv;
  logic [31:0] exec_pc, pc_new, mem_addr, instr, mtvec, mepc, mstatus;
  logic        trap_busy;

  core_trap_seq_if #(.XLEN(32)) bus ();

  core_trap_seq #(.XLEN(32), .VECTORED(1'b1)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ex_exec_illegal_instr (ill),
    .ex_instr_misaligned   (imis),
    .ex_ecall              (ecall),
    .ex_ebreak             (ebreak),
    .ex_load_misaligned    (lmis),
    .ex_store_misaligned   (smis),
    .irq_pending           (irq_pending),
    .irq_cause             (irq_cause),
    .instr_boundary        (instr_boundary),
    .mret                  (mret),
    .priv                  (priv),
    .exec_pc               (exec_pc),
    .pc_new                (pc_new),
    .mem_addr              (mem_addr),
    .instr                 (instr),
    .mtvec                 (mtvec),
    .mepc                  (mepc),
    .mstatus               (mstatus),
    .trap_busy             (trap_busy),
    .csr_bus               (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  bit          redir_pend = 1'b0;
  logic [31:0] exp_target;
  logic [1:0]  exp_priv;
  bit          chk_en = 1'b0;

  logic [31:0] last_mepc, last_mcause, last_mtval, last_mstatus, last_target;
  logic [1:0]  last_priv;
  int          last_redir_cyc = 0;
  int          redir_cnt = 0;
  int          ev_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle the DUT must match the head of the expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() != 0) begin
        chk("csr_we", 32'(bus.csr_we), 32'd1);
        chk("csr_waddr", 32'(bus.csr_waddr), 32'(exp_q[0].a));
        chk("csr_wdata", bus.csr_wdata, exp_q[0].d);
        chk("busy_during_write", 32'(trap_busy), 32'd1);
        chk("no_redirect_during_write", 32'(bus.pc_redirect_valid), 32'd0);
        if (bus.csr_we && bus.csr_wack) begin
          case (bus.csr_waddr)
            12'h341: last_mepc    = bus.csr_wdata;
            12'h342: last_mcause  = bus.csr_wdata;
            12'h343: last_mtval   = bus.csr_wdata;
            12'h300: last_mstatus = bus.csr_wdata;
            default: ;
          endcase
          void'(exp_q.pop_front());
        end
      end else if (redir_pend) begin
        chk("redirect_valid", 32'(bus.pc_redirect_valid), 32'd1);
        chk("redirect_target", bus.pc_redirect, exp_target);
        chk("priv_set_valid", 32'(bus.priv_set_valid), 32'd1);
        chk("priv_set", 32'(bus.priv_set), 32'(exp_priv));
        chk("busy_during_redirect", 32'(trap_busy), 32'd1);
        chk("no_write_during_redirect", 32'(bus.csr_we), 32'd0);
        redir_pend = 1'b0;
      end else begin
        chk("idle_csr_we", 32'(bus.csr_we), 32'd0);
        chk("idle_redirect", 32'(bus.pc_redirect_valid), 32'd0);
        chk("idle_priv_set_valid", 32'(bus.priv_set_valid), 32'd0);
        chk("idle_busy", 32'(trap_busy), 32'd0);
      end
      if (bus.pc_redirect_valid) begin
        redir_cnt++;
        last_target    = bus.pc_redirect;
        last_priv      = bus.priv_set;
        last_redir_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    ill = 0; imis = 0; ecall = 0; ebreak = 0; lmis = 0; smis = 0;
    irq_pending = 0; mret = 0;
  endtask

  // Model: derive the event from the current inputs, let the DUT sample it,
  // then post the expected write sequence and redirect.
  task automatic issue();
    wr_t         tq[$];
    bit          trap = 1'b1;
    bit          is_irq = 1'b0;
    bit          is_ret = 1'b0;
    logic [3:0]  c = 4'd0;
    logic [31:0] tv = 32'd0;
    logic [31:0] ms;
    logic [31:0] tgt = 32'd0;
    logic [1:0]  pv = 2'b11;
    if (ill)               begin c = 4'd2; tv = instr; end
    else if (imis)         begin c = 4'd0; tv = pc_new; end
    else if (ecall)        begin c = (priv == 2'b11) ? 4'd11 : 4'd8; end
    else if (ebreak)       begin c = 4'd3; end
    else if (smis)         begin c = 4'd6; tv = mem_addr; end
    else if (lmis)         begin c = 4'd4; tv = mem_addr; end
    else if (irq_pending && instr_boundary) begin is_irq = 1'b1; c = irq_cause; end
    else trap = 1'b0;
    ms = mstatus;
    if (trap) begin
      ms[7] = mstatus[3];
      ms[3] = 1'b0;
      ms[12:11] = priv;
      tq.push_back('{a: 12'h341, d: exec_pc & ~32'd3});
      tq.push_back('{a: 12'h342, d: {is_irq, 27'd0, c}});
      tq.push_back('{a: 12'h343, d: tv});
      tq.push_back('{a: 12'h300, d: ms});
      tgt = (mtvec & ~32'd3) + ((mtvec[0] && is_irq) ? 32'(c) * 32'd4 : 32'd0);
      pv  = 2'b11;
    end else if (mret) begin
      is_ret = 1'b1;
      ms[3] = mstatus[7];
      ms[7] = 1'b1;
      ms[12:11] = 2'b00;
      tq.push_back('{a: 12'h300, d: ms});
      tgt = mepc & ~32'd1;
      pv  = mstatus[12:11];
    end
    ev_cyc = cyc;
    step();
    clear_flags();
    foreach (tq[i]) exp_q.push_back(tq[i]);
    if (trap || is_ret) begin
      exp_target = tgt;
      exp_priv   = pv;
      redir_pend = 1'b1;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || redir_pend); i++) step();
    chk("sequence_completed", 32'(exp_q.size()) + 32'(redir_pend), 32'd0);
    exp_q.delete();
    redir_pend = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    rst_n = 0; clear_flags();
    irq_cause = 0; instr_boundary = 0; priv = 2'b11;
    exec_pc = 0; pc_new = 0; mem_addr = 0; instr = 0;
    mtvec = 32'h2000; mepc = 0; mstatus = 0;
    bus.csr_wack = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_csr_we", 32'(bus.csr_we), 32'd0);
    chk("rst_waddr", 32'(bus.csr_waddr), 32'd0);
    chk("rst_wdata", bus.csr_wdata, 32'd0);
    chk("rst_busy", 32'(trap_busy), 32'd0);
    chk("rst_redirect_valid", 32'(bus.pc_redirect_valid), 32'd0);
    chk("rst_redirect", bus.pc_redirect, 32'd0);
    chk("rst_priv_set_valid", 32'(bus.priv_set_valid), 32'd0);
    chk("rst_priv_set", 32'(bus.priv_set), 32'd0);
    step();
    rst_n = 1;
    chk_en = 1'b1;
    step();

    // illegal + load misaligned together: illegal wins
    ill = 1; lmis = 1; exec_pc = 32'h100; instr = 32'hFFFF_FFFF; mem_addr = 32'h55;
    priv = 2'b11; mstatus = 32'h8; mtvec = 32'h2000;
    issue(); wait_done();
    chk("t1_mepc", last_mepc, 32'h100);
    chk("t1_mcause", last_mcause, 32'd2);
    chk("t1_mtval", last_mtval, 32'hFFFF_FFFF);
    chk("t1_mstatus", last_mstatus, 32'h1880);
    chk("t1_target", last_target, 32'h2000);
    chk("t1_latency", 32'(last_redir_cyc - ev_cyc), 32'd5);

    // ecall from U-mode, misaligned exec_pc
    ecall = 1; priv = 2'b00; mstatus = 32'h8; exec_pc = 32'h107;
    issue(); wait_done();
    chk("t2_mcause", last_mcause, 32'd8);
    chk("t2_mstatus", last_mstatus, 32'h80);
    chk("t2_mtval", last_mtval, 32'd0);
    chk("t2_mepc", last_mepc, 32'h104);
    chk("t2_priv_set", 32'(last_priv), 32'd3);
    priv = 2'b11;

    // vectored interrupt
    irq_pending = 1; irq_cause = 4'd7; instr_boundary = 1; mtvec = 32'h1001;
    issue(); wait_done();
    chk("t3_mcause", last_mcause, 32'h8000_0007);
    chk("t3_target", last_target, 32'h101C);
    chk("t3_mtval", last_mtval, 32'd0);

    // interrupt off an instruction boundary is ignored
    rc = redir_cnt;
    irq_pending = 1; irq_cause = 4'd11; instr_boundary = 0;
    issue(); repeat (8) step();
    chk("t3b_no_irq", 32'(redir_cnt - rc), 32'd0);

    // exception beats a pending interrupt; exceptions are never vectored
    smis = 1; irq_pending = 1; irq_cause = 4'd3; instr_boundary = 1; mem_addr = 32'h3003;
    issue(); wait_done();
    chk("t3c_mcause", last_mcause, 32'd6);
    chk("t3c_mtval", last_mtval, 32'h3003);
    chk("t3c_target", last_target, 32'h1000);
    instr_boundary = 0; mtvec = 32'h2000;

    // csr_wack held low for three cycles in W_MCAUSE
    ebreak = 1; exec_pc = 32'h400;
    issue();
    step();
    bus.csr_wack = 1'b0;
    repeat (3) step();
    bus.csr_wack = 1'b1;
    wait_done();
    chk("t4_mcause", last_mcause, 32'd3);
    chk("t4_latency", 32'(last_redir_cyc - ev_cyc), 32'd8);

    // MRET back to M-mode
    mret = 1; mepc = 32'h203; mstatus = 32'h1880;
    issue(); wait_done();
    chk("t5_mstatus", last_mstatus, 32'h88);
    chk("t5_target", last_target, 32'h202);
    chk("t5_priv_set", 32'(last_priv), 32'd3);
    chk("t5_latency", 32'(last_redir_cyc - ev_cyc), 32'd2);

    // MRET back to U-mode
    mret = 1; mepc = 32'h8000_0001; mstatus = 32'h80;
    issue(); wait_done();
    chk("t5b_mstatus", last_mstatus, 32'h88);
    chk("t5b_target", last_target, 32'h8000_0000);
    chk("t5b_priv_set", 32'(last_priv), 32'd0);

    // instr misaligned beats ecall/ebreak and a simultaneous mret
    imis = 1; ecall = 1; ebreak = 1; mret = 1; pc_new = 32'h2222; mstatus = 32'h0;
    issue(); wait_done();
    chk("t6_mcause", last_mcause, 32'd0);
    chk("t6_mtval", last_mtval, 32'h2222);
    chk("t6_mstatus", last_mstatus, 32'h1800);

    // ecall from M-mode and a lone load misaligned
    ecall = 1; priv = 2'b11;
    issue(); wait_done();
    chk("t6b_mcause", last_mcause, 32'd11);
    lmis = 1; mem_addr = 32'h77;
    issue(); wait_done();
    chk("t6c_mcause", last_mcause, 32'd4);
    chk("t6c_mtval", last_mtval, 32'h77);

    // reset in W_MTVAL: abandon the sequence, no redirect
    rc = redir_cnt;
    ebreak = 1;
    issue();
    step();
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    exp_q.delete();
    redir_pend = 1'b0;
    repeat (6) step();
    chk("t7_no_redirect", 32'(redir_cnt - rc), 32'd0);
    chk("t7_idle_busy", 32'(trap_busy), 32'd0);
    last_mtval = 32'hDEAD_BEEF;
    ebreak = 1; instr = 32'h1234_5678;
    issue(); wait_done();
    chk("t7_mcause", last_mcause, 32'd3);
    chk("t7_mtval", last_mtval, 32'd0);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
